prog_ctr_unit: RTL
==================

Name: prog_ctr_unit

Overview:
- Program-counter and fetch-sequencing unit for the single-cycle CPU.
- Consumes the signed 8-bit relative branch offset produced by the branch lookup table, absolute jump targets, and call/return requests.
- Drives the instruction-memory address every cycle.
- Contains a small return-address stack and a run/halt state machine so the test harness can start a program and detect completion.

Parameters:
PW, 10, PC / instruction-address width in bits (PW >= 8)
SD, 4, return-address stack depth (entries, power of 2)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high; clears all state immediately
Start  in  1  begin execution at StartAddr (accepted in IDLE or DONE)
StartAddr  in  PW  program entry address
Stall  in  1  hold PC for this cycle
BranchRel  in  1  take relative branch: PC <= PC + sext(Offset)
Offset  in  8  signed branch offset from lookup table (default +1)
JumpAbs  in  1  absolute jump: PC <= Target
Target  in  PW  absolute jump / call destination
Call  in  1  push PC+1, PC <= Target
Ret  in  1  pop return address into PC
Halt  in  1  end of program
PC  out  PW  current instruction address
Running  out  1  high while in RUN
Done  out  1  high while in DONE
StackErr  out  1  sticky: stack overflow or underflow occurred

Behaviour:
- Reset (async, any time, including mid-program):
  - State=IDLE, PC=0, Running=0, Done=0, StackErr=0.
  - Stack pointer=0; all stack entries are invalid.
- States and transitions:
  - IDLE: Start -> RUN, PC<=StartAddr. All other control inputs are ignored.
  - RUN: Running=1. The update for the cycle is chosen by the priority below.
  - DONE: Done=1, PC frozen. Start -> RUN, PC<=StartAddr, stack emptied, StackErr cleared. All other inputs are ignored.
- RUN priority, highest first; exactly one action per cycle:
  1. Halt: -> DONE, PC unchanged.
  2. Stall: PC unchanged.
  3. Ret:
     - Stack non-empty: PC <= top entry; pop.
     - Stack empty: StackErr<=1, PC<=PC+1.
  4. Call:
     - Stack not full: push PC+1 (mod 2^PW), PC<=Target.
     - Stack full: push dropped, StackErr<=1, PC<=Target still.
  5. JumpAbs: PC<=Target.
  6. BranchRel: PC <= PC + sign-extend(Offset to PW), modulo 2^PW (wrap-around both directions, no error).
  7. None of the above: PC<=PC+1 (mod 2^PW); PC = 2^PW-1 wraps to 0.
- Latency: the request is sampled at the rising edge and the new PC is visible immediately after that edge. Single-cycle, no bubbles.
- Start asserted while in RUN: ignored.
- StackErr stays set until Reset or a Start accepted in DONE.
- Stack is LIFO with SD entries.
  - Push and pop are never performed in the same cycle, because of the priority order.
- Outputs are registered state (PC, state, StackErr). Running/Done are decoded from state only, with no combinational path from inputs.

Test Plan:
- Reset, then Start with StartAddr=0x010 → PC=0x010, Running=1. Five idle cycles → PC=0x015.
- PC=0x020, BranchRel with Offset=-7 (0xF9) → PC=0x019. Next cycle Offset=+20 → PC=0x02D. At PC=0x003, Offset=-4 → PC=0x3FF (wrap).
- Stall and BranchRel both high at PC=0x040 → PC stays 0x040. Halt and Call both high → DONE, PC=0x040, Done=1, stack unchanged.
- Call Target=0x100 at PC=0x050 → PC=0x100. Call Target=0x200 → PC=0x200. Ret → PC=0x101. Ret → PC=0x051, StackErr=0.
- Five Calls with SD=4 → fifth Call still jumps, StackErr=1. Four Rets return the correct addresses. Fifth Ret → PC+1, StackErr stays 1. Halt, then Start → StackErr=0, PC=StartAddr.
- Assert Reset mid-RUN, between clock edges → PC=0, state IDLE immediately. Deassert: BranchRel/Call are ignored until Start.

Source files
------------

// File: rtl/prog_ctr_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control, relative/absolute
// branching, and a small LIFO return-address stack with sticky error flag.
module prog_ctr_unit #(
    parameter int PW = 10,
    parameter int SD = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          BranchRel,
    input  logic [7:0]    Offset,
    input  logic          JumpAbs,
    input  logic [PW-1:0] Target,
    input  logic          Call,
    input  logic          Ret,
    input  logic          Halt,
    output logic [PW-1:0] PC,
    output logic          Running,
    output logic          Done,
    output logic          StackErr,
    output logic [1:0]    dbg_state
);

    localparam int SW = $clog2(SD);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [SW:0] SP_ONE  = 1;
    localparam logic [SW:0] SP_FULL = SD[SW:0];

    // Control inputs are level requests sampled on each rising edge; there is no
    // back-pressure, so any request seen while the state accepts it takes effect.
    logic [1:0]    state;
    logic [SW:0]   sp;
    logic [SW:0]   sp_dec;
    logic [PW-1:0] stk [SD];
    logic [PW-1:0] pc_inc;
    logic [PW-1:0] off_ext;
    logic          stk_empty;
    logic          stk_full;
    logic          push_en;

    assign pc_inc    = PC + PW'(1);
    assign off_ext   = PW'($signed(Offset));
    assign sp_dec    = sp - SP_ONE;
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_FULL);
    assign push_en   = (state == S_RUN) && !Halt && !Stall && !Ret && Call && !stk_full;

    assign Running   = (state == S_RUN);
    assign Done      = (state == S_DONE);
    assign dbg_state = state;

    // Entry contents need no reset: validity is carried entirely by sp.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            stk[sp[SW-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            PC       <= '0;
            sp       <= '0;
            StackErr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state <= S_RUN;
                        PC    <= StartAddr;
                    end
                end
                S_RUN: begin
                    if (Halt) begin
                        state <= S_DONE;
                    end else if (Stall) begin
                        PC <= PC;
                    end else if (Ret) begin
                        if (stk_empty) begin
                            StackErr <= 1'b1;
                            PC       <= pc_inc;
                        end else begin
                            PC <= stk[sp_dec[SW-1:0]];
                            sp <= sp_dec;
                        end
                    end else if (Call) begin
                        PC <= Target;
                        if (stk_full) begin
                            StackErr <= 1'b1;
                        end else begin
                            sp <= sp + SP_ONE;
                        end
                    end else if (JumpAbs) begin
                        PC <= Target;
                    end else if (BranchRel) begin
                        PC <= PC + off_ext;
                    end else begin
                        PC <= pc_inc;
                    end
                end
                S_DONE: begin
                    // Restart drops any leftover return addresses from the last program.
                    if (Start) begin
                        state    <= S_RUN;
                        PC       <= StartAddr;
                        sp       <= '0;
                        StackErr <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
